// File: rtl/multiword_alu_seq.sv
// Sequencer that runs an NWORDS-byte operation through an external 8-bit
// combinational ALU one byte per clock, chaining SC_OUT into the next SC_IN.
module multiword_alu_seq #(
    parameter int NWORDS = 2
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [8*NWORDS-1:0]   opa,
    input  logic [8*NWORDS-1:0]   opb,
    input  logic                  cin,
    output logic [7:0]            ALU_A,
    output logic [7:0]            ALU_B,
    output logic [2:0]            ALU_OP,
    output logic                  ALU_SC_IN,
    input  logic [7:0]            ALU_OUT,
    input  logic                  ALU_SC,
    input  logic                  ALU_ZERO,
    output logic                  busy,
    output logic                  done,
    output logic [8*NWORDS-1:0]   result,
    output logic                  sc_out,
    output logic                  zero
);

    localparam logic [2:0] kADD     = 3'd0;
    localparam logic [2:0] kLSH     = 3'd1;
    localparam logic [2:0] kRSH     = 3'd2;
    localparam logic [2:0] kXOR     = 3'd3;
    localparam logic [2:0] kAND     = 3'd4;
    localparam logic [2:0] kCompare = 3'd5;

    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_next;
    logic [2:0]           op_r;
    logic [8*NWORDS-1:0]  a_r;
    logic [8*NWORDS-1:0]  b_r;
    logic                 carry_r;
    logic                 zacc_r;
    logic [IDX_W-1:0]     idx_r;
    logic [8*NWORDS-1:0]  result_r;
    logic                 last_byte;

    // Right shifts walk MSW to LSW so the shifted-out bit lands in the lower byte's MSB.
    assign last_byte = (op_r == kRSH) ? (idx_r == '0) : (idx_r == IDX_LAST);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ALU_A      = '0;
        ALU_B      = '0;
        ALU_OP     = '0;
        ALU_SC_IN  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                ALU_A     = a_r[idx_r*8 +: 8];
                ALU_B     = b_r[idx_r*8 +: 8];
                ALU_OP    = op_r;
                ALU_SC_IN = carry_r;
                if (last_byte) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            carry_r  <= 1'b0;
            zacc_r   <= 1'b0;
            idx_r    <= '0;
            result_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r     <= op;
                        a_r      <= opa;
                        b_r      <= opb;
                        carry_r  <= cin;
                        zacc_r   <= 1'b1;
                        result_r <= '0;
                        idx_r    <= (op == kRSH) ? IDX_LAST : '0;
                    end
                end
                RUN: begin
                    result_r[idx_r*8 +: 8] <= ALU_OUT;
                    carry_r                <= ALU_SC;
                    zacc_r                 <= zacc_r & ALU_ZERO;
                    if (!last_byte) begin
                        idx_r <= (op_r == kRSH) ? idx_r - 1'b1 : idx_r + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Carry and zero accumulators hold after DONE, so they double as the outputs.
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign result = result_r;
    assign sc_out = carry_r;
    assign zero   = zacc_r;

endmodule

// File: tb/tb_multiword_alu_seq.sv
// Bench for multiword_alu_seq: behavioural 8-bit ALU stand-in plus a
// wide-word reference model, directed test-plan cases and random operations.
module tb_multiword_alu_seq;

    localparam int NWORDS = 2;
    localparam int W = 8 * NWORDS;

    localparam logic [2:0] kADD     = 3'd0;
    localparam logic [2:0] kLSH     = 3'd1;
    localparam logic [2:0] kRSH     = 3'd2;
    localparam logic [2:0] kXOR     = 3'd3;
    localparam logic [2:0] kAND     = 3'd4;
    localparam logic [2:0] kCompare = 3'd5;

    logic         CLK = 1'b0;
    logic         Reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         cin;
    logic [7:0]   ALU_A;
    logic [7:0]   ALU_B;
    logic [2:0]   ALU_OP;
    logic         ALU_SC_IN;
    logic [7:0]   ALU_OUT;
    logic         ALU_SC;
    logic         ALU_ZERO;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         sc_out;
    logic         zero;

    int n_checks = 0;
    int n_fail   = 0;

    multiword_alu_seq #(.NWORDS(NWORDS)) dut (
        .CLK(CLK), .Reset(Reset), .start(start), .op(op), .opa(opa), .opb(opb), .cin(cin),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .ALU_SC_IN(ALU_SC_IN),
        .ALU_OUT(ALU_OUT), .ALU_SC(ALU_SC), .ALU_ZERO(ALU_ZERO),
        .busy(busy), .done(done), .result(result), .sc_out(sc_out), .zero(zero)
    );

    always #5 CLK = ~CLK;

    // Combinational 8-bit ALU; Compare is a borrow-chained subtract A-B-SC_IN.
    logic [8:0] alu_t;
    always_comb begin
        alu_t    = '0;
        ALU_OUT  = '0;
        ALU_SC   = 1'b0;
        case (ALU_OP)
            kADD: begin
                alu_t   = {1'b0, ALU_A} + {1'b0, ALU_B} + 9'(ALU_SC_IN);
                ALU_OUT = alu_t[7:0];
                ALU_SC  = alu_t[8];
            end
            kLSH: begin
                ALU_OUT = {ALU_A[6:0], ALU_SC_IN};
                ALU_SC  = ALU_A[7];
            end
            kRSH: begin
                ALU_OUT = {ALU_SC_IN, ALU_A[7:1]};
                ALU_SC  = ALU_A[0];
            end
            kXOR: ALU_OUT = ALU_A ^ ALU_B;
            kAND: ALU_OUT = ALU_A & ALU_B;
            kCompare: begin
                alu_t   = {1'b0, ALU_A} - {1'b0, ALU_B} - 9'(ALU_SC_IN);
                ALU_OUT = alu_t[7:0];
                ALU_SC  = alu_t[8];
            end
            default: begin
            end
        endcase
        ALU_ZERO = (ALU_OUT == 8'h00);
    end

    // Whole-operand reference: what the wide operation must produce.
    task automatic ref_model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c, output logic [W-1:0] res, output logic sc);
        logic [W:0] s;
        res = '0;
        sc  = 1'b0;
        case (o)
            kADD: begin
                s = {1'b0, a} + {1'b0, b} + (W+1)'(c);
                res = s[W-1:0]; sc = s[W];
            end
            kLSH: begin
                res = (a << 1) | W'(c); sc = a[W-1];
            end
            kRSH: begin
                res = (a >> 1) | (W'(c) << (W-1)); sc = a[0];
            end
            kXOR: res = a ^ b;
            kAND: res = a & b;
            kCompare: begin
                s = {1'b0, a} - {1'b0, b} - (W+1)'(c);
                res = s[W-1:0]; sc = s[W];
            end
            default: begin
            end
        endcase
    endtask

    // Carry/borrow that must enter byte j, derived from the low-order part of the operands.
    function automatic logic exp_cin(input logic [2:0] o, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic c, input int j);
        logic [W:0] m, lo_a, lo_b;
        m    = (W+1)'(1) << (8*j);
        lo_a = {1'b0, a} & (m - 1);
        lo_b = {1'b0, b} & (m - 1);
        if (o == kRSH) return (j == NWORDS-1) ? c : a[8*(j+1)];
        if (j == 0) return c;
        case (o)
            kADD:     return (lo_a + lo_b + (W+1)'(c)) >= m;
            kCompare: return lo_a < (lo_b + (W+1)'(c));
            kLSH:     return a[8*j-1];
            default:  return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_alu_idle(input string tag);
        check({tag, "_alu_a"}, ALU_A, 0);
        check({tag, "_alu_b"}, ALU_B, 0);
        check({tag, "_alu_op"}, ALU_OP, 0);
        check({tag, "_alu_sc_in"}, ALU_SC_IN, 0);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c);
        logic [W-1:0] er;
        logic         es;
        int           j;
        ref_model(o, a, b, c, er, es);
        op = o; opa = a; opb = b; cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < NWORDS; i++) begin
            j = (o == kRSH) ? NWORDS-1-i : i;
            check("run_busy", busy, 1);
            check("run_done", done, 0);
            check("run_alu_a", ALU_A, a[8*j +: 8]);
            check("run_alu_b", ALU_B, b[8*j +: 8]);
            check("run_alu_op", ALU_OP, o);
            check("run_alu_sc_in", ALU_SC_IN, exp_cin(o, a, b, c, j));
            opa = W'({$urandom, $urandom});
            opb = W'({$urandom, $urandom});
            op  = 3'($urandom_range(0, 5));
            cin = 1'($urandom);
            tick();
        end
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_result", result, er);
        check("done_sc_out", sc_out, es);
        check("done_zero", zero, er == '0);
        check_alu_idle("done");
        tick();
        check("after_done", done, 0);
        check("after_busy", busy, 0);
        check("hold_result", result, er);
        check("hold_sc_out", sc_out, es);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dones;
        Reset = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0; cin = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_sc_out", sc_out, 0);
        check("rst_zero", zero, 0);
        check_alu_idle("rst");
        Reset = 1'b0;
        tick();

        run_op(kADD, 16'h00FF, 16'h0001, 1'b0);
        check("add1_result", result, 16'h0100);
        check("add1_zero", zero, 0);
        run_op(kADD, 16'hFFFF, 16'h0001, 1'b0);
        check("add2_result", result, 16'h0000);
        check("add2_sc_out", sc_out, 1);
        check("add2_zero", zero, 1);
        run_op(kLSH, 16'h80B3, 16'h0000, 1'b1);
        check("lsh_result", result, 16'h0167);
        check("lsh_sc_out", sc_out, 1);
        run_op(kRSH, 16'h0101, 16'h0000, 1'b0);
        check("rsh_result", result, 16'h0080);
        check("rsh_sc_out", sc_out, 1);
        run_op(kXOR, 16'hA5A5, 16'hA5A5, 1'b1);
        check("xor_result", result, 16'h0000);
        check("xor_zero", zero, 1);
        check("xor_sc_out", sc_out, 0);
        run_op(kAND, 16'hF00F, 16'h0FF0, 1'b0);
        check("and_result", result, 16'h0000);
        check("and_zero", zero, 1);
        run_op(kCompare, 16'h1234, 16'h1235, 1'b0);
        check("cmp_sc_out", sc_out, 1);

        // start held high: one done pulse per pass through IDLE
        op = kADD; opa = 16'h0102; opb = 16'h0304; cin = 1'b0; start = 1'b1;
        dones = 0;
        for (int i = 0; i < 2*NWORDS + 4; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        start = 1'b0;
        check("held_start_dones", dones, 2);
        check("held_start_result", result, 16'h0406);
        tick();

        // reset during the first RUN cycle aborts the operation
        op = kADD; opa = 16'h1111; opb = 16'h2222; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_busy_pre", busy, 1);
        Reset = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check_alu_idle("abort");
        Reset = 1'b0;
        tick();
        check("abort_no_done", done, 0);
        check("abort_idle", busy, 0);

        // reset coincident with start: nothing accepted
        Reset = 1'b1; start = 1'b1;
        tick();
        Reset = 1'b0; start = 1'b0;
        check("rst_start_busy", busy, 0);
        tick();
        check("rst_start_still_idle", busy, 0);
        check("rst_start_no_done", done, 0);

        for (int n = 0; n < 24; n++) begin
            run_op(3'($urandom_range(0, 5)), W'({$urandom, $urandom}),
                   W'({$urandom, $urandom}), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
